// File: rtl/mc_backend_pkg.sv
// rtl/mc_backend_pkg.sv - shared memory-controller backend types and defaults
package mc_backend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2
  } bgf_state_e;

  localparam int NUM_BANKS = 4;
  localparam int BURST_LEN = 8;
  localparam int REQ_W     = 32;

  typedef logic [REQ_W-1:0] cmd_t;

endpackage

// File: rtl/bank_group_burst_fsm_rr_pick.sv
// rtl/bank_group_burst_fsm_rr_pick.sv - combinational round-robin first-one finder
// Returns the first set request at or after ptr, wrapping past N-1 to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  // Scanning from the far end lets the nearest candidate win by overwriting.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) idx = PW'((int'(ptr) + i) % N);
    end
  end

endmodule

// File: rtl/bank_group_burst_fsm.sv
// rtl/bank_group_burst_fsm.sv - per-bank-group burst responder to the group arbiter
// Optional row-hit-first bank selection when BGF_ROW_HIT_PRIO_EN is defined.
module bank_group_burst_fsm #(
  parameter int NUM_BANKS = mc_backend_pkg::NUM_BANKS,
  parameter int BURST_LEN = mc_backend_pkg::BURST_LEN,
  parameter int REQ_W     = mc_backend_pkg::REQ_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANKS-1:0]         bank_valid_i,
  input  logic [NUM_BANKS-1:0]         bank_last_i,
  input  logic [NUM_BANKS*REQ_W-1:0]   bank_data_i,
  input  logic [NUM_BANKS-1:0]         bank_hit_i,
  output logic [NUM_BANKS-1:0]         bank_pop_o,
  input  logic                         start_i,
  output logic                         req_o,
  output logic                         done_o,
  output logic                         xfer_valid_o,
  output logic [REQ_W-1:0]             xfer_data_o,
  output logic [$clog2(NUM_BANKS)-1:0] xfer_bank_o
);

  import mc_backend_pkg::*;

  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(BURST_LEN + 1);

  bgf_state_e    state_q, state_d;
  logic [BW-1:0] cur_bank, rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic          pick_any;
  logic [BW-1:0] pick_idx;
  logic          active, cur_valid, xfer, done;

`ifdef BGF_ROW_HIT_PRIO_EN
  logic          hit_any, all_any;
  logic [BW-1:0] hit_idx, all_idx;

  rr_pick #(.N(NUM_BANKS), .PW(BW)) u_hit_pick (
    .req (bank_valid_i & bank_hit_i),
    .ptr (rr_ptr),
    .any (hit_any),
    .idx (hit_idx)
  );

  rr_pick #(.N(NUM_BANKS), .PW(BW)) u_all_pick (
    .req (bank_valid_i),
    .ptr (rr_ptr),
    .any (all_any),
    .idx (all_idx)
  );

  assign pick_any = all_any;
  assign pick_idx = hit_any ? hit_idx : all_idx;
`else
  logic unused_hit;
  assign unused_hit = ^bank_hit_i;

  rr_pick #(.N(NUM_BANKS), .PW(BW)) u_all_pick (
    .req (bank_valid_i),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );
`endif

  // Gating with rst_n keeps a reset cycle from popping a bank mid-burst.
  assign active    = (state_q != IDLE);
  assign cur_valid = bank_valid_i[cur_bank];
  assign xfer      = rst_n & active & start_i & cur_valid;
  assign done      = rst_n & active & start_i &
                     (~cur_valid | bank_last_i[cur_bank] | (beat_cnt == CW'(BURST_LEN - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (pick_any) state_d = ARMED;
      ARMED, BURST: if (done) state_d = IDLE;
                    else if (xfer) state_d = BURST;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_bank <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (!active) begin
      if (pick_any) cur_bank <= pick_idx;
    end else if (done) begin
      beat_cnt <= '0;
      rr_ptr   <= (cur_bank == BW'(NUM_BANKS - 1)) ? '0 : cur_bank + 1'b1;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_comb begin
    bank_pop_o           = '0;
    bank_pop_o[cur_bank] = xfer;
    req_o                = active;
    done_o               = done;
    xfer_valid_o         = xfer;
    xfer_data_o          = active ? bank_data_i[cur_bank*REQ_W +: REQ_W] : '0;
    xfer_bank_o          = active ? cur_bank : '0;
  end

endmodule

// File: tb/tb_bank_group_burst_fsm.sv
// tb/tb_bank_group_burst_fsm.sv - scoreboard bench for bank_group_burst_fsm
module tb_bank_group_burst_fsm;

  localparam int NB = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NB-1:0]   bank_valid_i, bank_last_i, bank_hit_i, bank_pop_o;
  logic [NB*W-1:0] bank_data_i;
  logic            start_i, req_o, done_o, xfer_valid_o;
  logic [W-1:0]    xfer_data_o;
  logic [1:0]      xfer_bank_o;

  bank_group_burst_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bank_valid_i (bank_valid_i),
    .bank_last_i  (bank_last_i),
    .bank_data_i  (bank_data_i),
    .bank_hit_i   (bank_hit_i),
    .bank_pop_o   (bank_pop_o),
    .start_i      (start_i),
    .req_o        (req_o),
    .done_o       (done_o),
    .xfer_valid_o (xfer_valid_o),
    .xfer_data_o  (xfer_data_o),
    .xfer_bank_o  (xfer_bank_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] pop;
    logic          valid;
    logic          done;
    logic [1:0]    bank;
    logic [W-1:0]  data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   cnt[NB];
  int   head[NB];

  function automatic logic [W-1:0] dat(input int b, input int i);
    return 32'hB000_0000 | (b << 16) | i;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive();
    for (int b = 0; b < NB; b++) begin
      bank_valid_i[b]           = (cnt[b] > 0);
      bank_last_i[b]            = (cnt[b] == 1);
      bank_data_i[b*W +: W]     = dat(b, head[b]);
    end
  endtask

  // Bank scheduler model: a pop seen in a cycle dequeues the head at the edge.
  task automatic step();
    logic [NB-1:0] p;
    @(negedge clk);
    p = bank_pop_o;
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) if (p[b]) begin cnt[b]--; head[b]++; end
    drive();
  endtask

  task automatic push_xfers(input int b, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pop = '0; e.pop[b] = 1'b1;
      e.valid = 1'b1;
      e.done = (i == n - 1);
      e.bank = 2'(b);
      e.data = dat(b, first + i);
      q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin step(); n++; end while (q.size() != 0 && n < 40);
    if (q.size() != 0) begin
      chk({name, "_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // IDLE -> ARMED, then grant and run until every expected transfer has appeared.
  task automatic burst(input string name);
    step();
    chk({name, "_req_armed"}, 32'(req_o), 32'd1);
    start_i = 1'b1;
    drain(name);
    chk({name, "_req_after_done"}, 32'(req_o), 32'd0);
    start_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (xfer_valid_o || done_o)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {28'd0, bank_pop_o}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop",   32'(bank_pop_o),   32'(e.pop));
        chk("valid", 32'(xfer_valid_o), 32'(e.valid));
        chk("done",  32'(done_o),       32'(e.done));
        chk("bank",  32'(xfer_bank_o),  32'(e.bank));
        if (e.valid) chk("data", xfer_data_o, e.data);
      end
    end
  end

  initial begin
    for (int b = 0; b < NB; b++) begin cnt[b] = 0; head[b] = 0; end
    rst_n = 1'b0; start_i = 1'b1; bank_hit_i = '0;
    cnt[2] = 3;
    drive();
    step();
    step();
    chk("rst_req",   32'(req_o),        32'd0);
    chk("rst_pop",   32'(bank_pop_o),   32'd0);
    chk("rst_done",  32'(done_o),       32'd0);
    chk("rst_valid", 32'(xfer_valid_o), 32'd0);
    chk("rst_data",  xfer_data_o,       32'd0);
    rst_n = 1'b1; start_i = 1'b0;
    chk("idle_req", 32'(req_o), 32'd0);

    // Bank 2, three entries, last on the third.
    push_xfers(2, 0, 3);
    burst("b2_three");

    // rr_ptr now 3: bank 3 wins over bank 0, then pointer wraps to bank 0.
    cnt[0] = 1; cnt[3] = 1; drive();
    push_xfers(3, 0, 1);
    burst("rr3_pick3");
    push_xfers(0, 0, 1);
    burst("rr0_pick0");

    // Long bank capped at BURST_LEN, then bank 1 picked next.
    cnt[0] = 20; drive();
    push_xfers(0, 1, 8);
    burst("len8");
    cnt[1] = 2; drive();
    push_xfers(1, 0, 2);
    burst("next_bank1");

    // Banks 1 and 3 with rr_ptr 2.
    cnt[0] = 0; cnt[1] = 1; cnt[3] = 1; drive();
    push_xfers(3, 1, 1);
    burst("rr2_pick3");
    push_xfers(1, 2, 1);
    burst("rr0_pick1");

    // Grant pauses mid-burst.
    cnt[0] = 12; drive();
    push_xfers(0, 9, 8);
    step();
    chk("pause_req_armed", 32'(req_o), 32'd1);
    start_i = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      start_i = 1'b0;
      #2;
      chk("pause_pop",   32'(bank_pop_o),   32'd0);
      chk("pause_valid", 32'(xfer_valid_o), 32'd0);
      chk("pause_req",   32'(req_o),        32'd1);
      step();
    end
    start_i = 1'b1;
    drain("pause");
    chk("pause_req_after_done", 32'(req_o), 32'd0);
    start_i = 1'b0;

    // Bank empties under a pending grant: abort.
    step();
    chk("abort_req_armed", 32'(req_o), 32'd1);
    cnt[0] = 0; drive();
    begin
      exp_t e;
      e.pop = '0; e.valid = 1'b0; e.done = 1'b1; e.bank = 2'd0; e.data = '0;
      q.push_back(e);
    end
    start_i = 1'b1;
    drain("abort");
    chk("abort_req_idle", 32'(req_o), 32'd0);
    start_i = 1'b0;

    // Bring rr_ptr back to 0, then row-hit preference case.
    cnt[3] = 1; drive();
    push_xfers(3, 2, 1);
    burst("rr_to0");
    cnt[0] = 1; cnt[2] = 1; bank_hit_i = 4'b0100; drive();
`ifdef BGF_ROW_HIT_PRIO_EN
    push_xfers(2, 3, 1);
    burst("hit_first");
    push_xfers(0, 17, 1);
    burst("hit_second");
`else
    push_xfers(0, 17, 1);
    burst("rr_first");
    push_xfers(2, 3, 1);
    burst("rr_second");
`endif
    bank_hit_i = '0;

    // Reset during a burst: no pop while reset is asserted.
    cnt[1] = 5; drive();
    push_xfers(1, 3, 1);
    q[0].done = 1'b0;
    step();
    start_i = 1'b1;
    step();
    rst_n = 1'b0;
    #2;
    chk("midrst_pop",  32'(bank_pop_o), 32'd0);
    chk("midrst_done", 32'(done_o),     32'd0);
    step();
    rst_n = 1'b1;
    start_i = 1'b0;
    chk("midrst_req",    32'(req_o),    32'd0);
    chk("midrst_popped", 32'(cnt[1]),   32'd4);
    chk("queue_empty",   32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bank_group_burst_fsm.md
Name: bank_group_burst_fsm

Overview:
- Bank-group-side responder to the group-level burst arbiter. One instance per bank group (A..D).
- Raises a request to the arbiter when any bank scheduler in its group holds a pending command.
- On the arbiter's start level, drains one command per cycle from a single locked bank into the shared burst buffer path.
- Signals done on the final transfer of the burst.

Parameters:
- NUM_BANKS, 4, bank schedulers per group.
- BURST_LEN, 8, maximum transfers per granted burst.
- REQ_W, 32, width of one scheduled command word.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- bank_valid_i  in  NUM_BANKS  bank scheduler head entry valid
- bank_last_i  in  NUM_BANKS  head entry is the bank's last pending entry
- bank_data_i  in  NUM_BANKS*REQ_W  head command per bank, bank 0 in LSBs
- bank_hit_i  in  NUM_BANKS  head is a row hit (used only with the optional feature)
- bank_pop_o  out  NUM_BANKS  one-hot dequeue pulse to the bank scheduler
- start_i  in  1  grant level from the group arbiter
- req_o  out  1  group request to the arbiter
- done_o  out  1  burst complete, to the arbiter
- xfer_valid_o  out  1  command transferred this cycle (write strobe)
- xfer_data_o  out  REQ_W  transferred command
- xfer_bank_o  out  $clog2(NUM_BANKS)  source bank of the transfer

Behaviour:
- States: IDLE, ARMED, BURST. Registers: cur_bank, rr_ptr, beat_cnt ($clog2(BURST_LEN+1) bits).
- Reset values: state IDLE, cur_bank 0, rr_ptr 0, beat_cnt 0. All outputs 0 during and after reset until the state changes.
- IDLE:
  - req_o=0.
  - If |bank_valid_i: cur_bank <= round-robin pick starting at rr_ptr (first valid index at or after rr_ptr, wrapping); go ARMED.
  - start_i is ignored in IDLE.
- ARMED and BURST:
  - req_o=1.
  - xfer = start_i & bank_valid_i[cur_bank]. All transfer outputs are combinational, same cycle as start_i:
    - bank_pop_o[cur_bank]=xfer
    - xfer_valid_o=xfer
    - xfer_data_o=bank_data_i slice [cur_bank]
    - xfer_bank_o=cur_bank
  - On xfer: beat_cnt++ and state goes to BURST.
- done_o (combinational):
  - Asserted on xfer & (beat_cnt==BURST_LEN-1 | bank_last_i[cur_bank]).
  - Also asserted on start_i & ~bank_valid_i[cur_bank] (abort; no pop).
- On done_o: next state IDLE, beat_cnt <= 0, rr_ptr <= cur_bank+1 modulo NUM_BANKS (wrap at NUM_BANKS-1 → 0).
- req_o drops in the cycle after done_o. The earliest re-request is 2 cycles after done_o (IDLE → ARMED).
- start_i low in ARMED/BURST: pause. beat_cnt and cur_bank are held, there are no pops, and req_o stays 1. This covers the arbiter dropping to idle on a full buffer.
- A burst never switches bank. done_o is never asserted without start_i.
- BURST_LEN=1: every transfer is a done cycle.
- Reset mid-burst: state returns to IDLE and no pop is issued in the reset cycle. The partial burst is abandoned; already-popped entries are not replayed.

Optional Feature:
- Macro: BGF_ROW_HIT_PRIO_EN.
- Defined: IDLE selection first picks round-robin among banks with bank_valid_i & bank_hit_i. If that set is empty, it falls back to round-robin among bank_valid_i.
- Undefined: pure round-robin; bank_hit_i is unused.

Decomposition:
- Shared package mc_backend_pkg holds:
  - enum bgf_state_e {IDLE, ARMED, BURST};
  - default constants NUM_BANKS, BURST_LEN, REQ_W;
  - typedef for the command word.
- One sub-module: rr_pick. Combinational round-robin first-one finder over NUM_BANKS with a pointer input. It is instantiated twice when BGF_ROW_HIT_PRIO_EN is defined.

Test Plan:
- Bank 2 holds 3 entries (last on 3rd), start_i held high → pops bank 2 on 3 consecutive cycles, done_o on the 3rd, req_o=0 on the next cycle, rr_ptr=3.
- Bank 0 holds 20 entries, BURST_LEN=8 → done_o on the 8th transfer. Then IDLE → ARMED, cur_bank=1 if bank 1 is valid, else wrap back to 0.
- Banks 1 and 3 valid, rr_ptr=2 → cur_bank=3. After done, rr_ptr=0 and the next pick is 1.
- start_i toggles 1,0,0,1 mid-burst → beat_cnt holds across the low cycles, no pops while low, total transfers still 8.
- Bank empties unexpectedly (valid=0, start_i=1) → done_o=1 with xfer_valid_o=0, state goes IDLE.
- BGF_ROW_HIT_PRIO_EN defined: banks 0 and 2 valid, only bank 2 hit, rr_ptr=0 → cur_bank=2. Without the macro → cur_bank=0.
